bit_serializer: RTL

//  Parallel-to-serial front end for the serial sequence detectors (e.g. the Moore 1010 detector).

---
 rtl/bit_serializer_if.sv | 33 +++
 rtl/bit_serializer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/bit_serializer_if.sv
// bit_serializer_if
//   Bundles the word handshake and the serial output of bit_serializer.
//   Handshake: a word moves on a rising clk edge where din_valid && din_ready.
//   The producer holds din_valid and din stable until that edge. The consumer
//   may raise or lower din_ready in any cycle.
//   Ports:
//     din, din_valid         producer -> serializer  (parallel word + valid)
//     din_ready              serializer -> producer
//     sout, sout_valid       serial bit and its qualifier
//     busy, word_done        status: SHIFT/GAP occupancy, last-bit pulse
//   modport slave  : serializer side
//   modport master : producer / observer side
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             word_done;

    modport slave (
        input  din, din_valid,
        output din_ready, sout, sout_valid, busy, word_done
    );

    modport master (
        output din, din_valid,
        input  din_ready, sout, sout_valid, busy, word_done
    );
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial front end for the serial sequence detectors. Accepts
//   WIDTH-bit words on a valid/ready handshake and shifts them out one bit
//   per clk on sout, with sout_valid qualifying each bit.
//   Optional feature macro: SER_PARITY_EN -- appends one even-parity bit
//   (^din) after the data bits of every word.
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous, active-low reset
//     bus        bit_serializer_if.slave (din, din_valid, din_ready, sout,
//                sout_valid, busy, word_done)
//     dbg_state  current FSM state (0 IDLE, 1 SHIFT, 2 GAP)
//   Parameters: WIDTH (2..32), MSB_FIRST (1 = din[WIDTH-1] first), GAP (0..15)
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    bit_serializer_if.slave       bus,
    output logic [1:0]            dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 2);
`ifdef SER_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif
    localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);
    // Gap counter counts down from GAP-1 to 0, giving exactly GAP idle cycles.
    localparam logic [3:0]    GAP_LOAD = 4'((GAP > 0) ? GAP - 1 : 0);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             word_done_q, word_done_d;
`ifdef SER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic din_ready;
    logic accept;

    // Ready in IDLE, and during the last bit when there is no gap so that the
    // next word follows without a bubble.
    assign din_ready = (state_q == S_IDLE) ||
                       ((state_q == S_SHIFT) && (bit_cnt_q == LAST_IDX) && (GAP == 0));
    assign accept    = bus.din_valid && din_ready;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        word_done_d  = 1'b0;
`ifdef SER_PARITY_EN
        parity_d     = parity_q;
`endif
        if (accept) begin
            // The first bit is presented straight from din on the accept edge;
            // the shift register keeps only the bits still to be sent.
            state_d      = S_SHIFT;
            bit_cnt_d    = '0;
            sout_valid_d = 1'b1;
            if (MSB_FIRST) begin
                sout_d  = bus.din[WIDTH-1];
                shreg_d = {bus.din[WIDTH-2:0], 1'b0};
            end else begin
                sout_d  = bus.din[0];
                shreg_d = {1'b0, bus.din[WIDTH-1:1]};
            end
`ifdef SER_PARITY_EN
            parity_d = ^bus.din;
`endif
        end else begin
            case (state_q)
                S_SHIFT: begin
                    if (bit_cnt_q == LAST_IDX) begin
                        bit_cnt_d = '0;
                        shreg_d   = '0;
                        if (GAP > 0) begin
                            state_d   = S_GAP;
                            gap_cnt_d = GAP_LOAD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_cnt_d    = bit_cnt_q + CW'(1);
                        sout_valid_d = 1'b1;
                        word_done_d  = (bit_cnt_d == LAST_IDX);
                        if (MSB_FIRST) begin
                            sout_d  = shreg_q[WIDTH-1];
                            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        end else begin
                            sout_d  = shreg_q[0];
                            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                        end
`ifdef SER_PARITY_EN
                        if (bit_cnt_d == CW'(WIDTH)) begin
                            sout_d = parity_q;
                        end
`endif
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == 4'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            word_done_q  <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            word_done_q  <= word_done_d;
`ifdef SER_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign bus.din_ready  = din_ready;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = sout_valid_q;
    assign bus.word_done  = word_done_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign dbg_state      = state_q;
endmodule
